// File: rtl/fifo_pkg.sv
// Shared types and helpers for the first-word-fall-through FIFO.
package fifo_pkg;

   // Read-path occupancy: nothing held, output register only, or output register plus memory.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      MANY  = 2'd2
   } rd_state_t;

   // Modulo-depth pointer increment with an explicit wrap; safe for any depth.
   function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array: synchronous write, combinational read, no reset on contents.
module fifo_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port: one word per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with a registered head word (first-word-fall-through),
// occupancy level, almost-full/empty thresholds and sticky error flags.
//
// state | meaning
// EMPTY | nothing held, output register invalid
// ONE   | head word in output register, memory empty
// MANY  | head word in output register, further words in memory
module sync_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int AF_TH  = DEPTH - 1,
   parameter int AE_TH  = 1,
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int ADDR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [CNT_W-1:0] level,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LVL_AF   = CNT_W'(AF_TH);
   localparam logic [CNT_W-1:0] LVL_AE   = CNT_W'(AE_TH);

   rd_state_t         state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  level_nxt;
   logic [WIDTH-1:0]  mem_rdata;
   logic              wr_fire, rd_fire;
   logic              bypass, mem_we, mem_pop;

   assign wr_ready     = (level != LVL_FULL);
   assign rd_valid     = (state != EMPTY);
   assign almost_full  = (level >= LVL_AF);
   assign almost_empty = (level <= LVL_AE);
   assign wr_fire      = wr_valid & wr_ready;
   assign rd_fire      = rd_valid & rd_ready;

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk  (clk),
      .we   (mem_we),
      .waddr(wr_ptr),
      .wdata(wr_data),
      .raddr(rd_ptr),
      .rdata(mem_rdata)
   );

   // Route writes to the output register when memory is empty and the head slot is free or draining.
   always_comb begin
      bypass    = 1'b0;
      mem_pop   = 1'b0;
      level_nxt = level;
      state_nxt = state;
      case (state)
         EMPTY:   bypass = wr_fire;
         ONE:     bypass = wr_fire & rd_fire;
         MANY:    mem_pop = rd_fire;
         default: bypass = 1'b0;
      endcase
      if (wr_fire && !rd_fire)      level_nxt = level + 1'b1;
      else if (!wr_fire && rd_fire) level_nxt = level - 1'b1;
      if (level_nxt == '0)                  state_nxt = EMPTY;
      else if (level_nxt == CNT_W'(1))      state_nxt = ONE;
      else                                  state_nxt = MANY;
   end

   assign mem_we = wr_fire & ~bypass;

   // Registered occupancy, pointers and head word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= EMPTY;
         level   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_data <= '0;
      end else begin
         state <= state_nxt;
         level <= level_nxt;
         if (mem_we)  wr_ptr <= ADDR_W'(next_ptr(32'(wr_ptr), DEPTH));
         if (mem_pop) rd_ptr <= ADDR_W'(next_ptr(32'(rd_ptr), DEPTH));
         if (bypass)       rd_data <= wr_data;
         else if (mem_pop) rd_data <= mem_rdata;
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr_valid & ~wr_ready) | (overflow  & ~clr_err);
         underflow <= (rd_ready & ~rd_valid) | (underflow & ~clr_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a DEPTH=4 and a DEPTH=5 instance checked
// every cycle against queue-based reference models.
module tb_sync_fifo_fwft;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]      wv, wrdy, rv, rr, af, ae, ov, uf, ce;
   logic [1:0][7:0] wd, rdd;
   logic [1:0][2:0] lvl;

   int n_tests = 0;
   int n_fail  = 0;

   int depth [2] = '{4, 5};
   int af_th [2] = '{3, 4};

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       m_ov [2];
   logic       m_uf [2];

   sync_fifo_fwft #(.WIDTH(8), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .wr_data(wd[0]), .wr_valid(wv[0]), .wr_ready(wrdy[0]),
      .rd_data(rdd[0]), .rd_valid(rv[0]), .rd_ready(rr[0]), .level(lvl[0]),
      .almost_full(af[0]), .almost_empty(ae[0]), .overflow(ov[0]), .underflow(uf[0]),
      .clr_err(ce[0])
   );

   sync_fifo_fwft #(.WIDTH(8), .DEPTH(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .wr_data(wd[1]), .wr_valid(wv[1]), .wr_ready(wrdy[1]),
      .rd_data(rdd[1]), .rd_valid(rv[1]), .rd_ready(rr[1]), .level(lvl[1]),
      .almost_full(af[1]), .almost_empty(ae[1]), .overflow(ov[1]), .underflow(uf[1]),
      .clr_err(ce[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int msize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [7:0] mhead(input int i);
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_ov[i] = 1'b0;
         m_uf[i] = 1'b0;
      end
   endtask

   task automatic check_inst(input int i);
      int sz;
      sz = msize(i);
      chk($sformatf("wr_ready[%0d]", i), 32'(wrdy[i]), 32'(sz != depth[i]));
      chk($sformatf("rd_valid[%0d]", i), 32'(rv[i]), 32'(sz > 0));
      chk($sformatf("level[%0d]", i), 32'(lvl[i]), 32'(sz));
      chk($sformatf("almost_full[%0d]", i), 32'(af[i]), 32'(sz >= af_th[i]));
      chk($sformatf("almost_empty[%0d]", i), 32'(ae[i]), 32'(sz <= 1));
      chk($sformatf("overflow[%0d]", i), 32'(ov[i]), 32'(m_ov[i]));
      chk($sformatf("underflow[%0d]", i), 32'(uf[i]), 32'(m_uf[i]));
      if (sz > 0) chk($sformatf("rd_data[%0d]", i), 32'(rdd[i]), 32'(mhead(i)));
   endtask

   // Starts just after a rising edge: check at the falling edge, advance the model, cross the next rising edge.
   task automatic cycle();
      bit full, wf, rf;
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_inst(i);
      for (int i = 0; i < 2; i++) begin
         full = (msize(i) == depth[i]);
         wf   = wv[i] && !full;
         rf   = rr[i] && (msize(i) > 0);
         m_ov[i] = (wv[i] && full) || (m_ov[i] && !ce[i]);
         m_uf[i] = (rr[i] && msize(i) == 0) || (m_uf[i] && !ce[i]);
         if (i == 0) begin
            if (rf) void'(q0.pop_front());
            if (wf) q0.push_back(wd[0]);
         end else begin
            if (rf) void'(q1.pop_front());
            if (wf) q1.push_back(wd[1]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wv = '0; rr = '0; ce = '0; wd = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #12;
      for (int i = 0; i < 2; i++) check_inst(i);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Three writes with the sink stalled.
      wv = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wd[0] = 8'hA1 + 8'(k * 8'h11);
         wd[1] = wd[0];
         cycle();
      end
      idle();
      cycle();
      chk("abc_level", 32'(lvl[0]), 32'd3);
      chk("abc_head", 32'(rdd[0]), 32'hA1);
      chk("abc_af", 32'(af[0]), 32'd1);

      // Fill DEPTH=4 and keep pushing two more cycles.
      wv[0] = 1'b1;
      wd[0] = 8'hD4;
      for (int k = 0; k < 3; k++) cycle();
      idle();
      cycle();
      chk("full_wr_ready", 32'(wrdy[0]), 32'd0);
      chk("full_level", 32'(lvl[0]), 32'd4);
      chk("full_overflow", 32'(ov[0]), 32'd1);
      ce[0] = 1'b1;
      cycle();
      idle();
      cycle();
      chk("clr_overflow", 32'(ov[0]), 32'd0);

      // Drain both, then read one extra cycle on an empty FIFO.
      rr = 2'b11;
      for (int k = 0; k < 5; k++) cycle();
      idle();
      rr[0] = 1'b1;
      cycle();
      idle();
      cycle();
      chk("udf_flag", 32'(uf[0]), 32'd1);
      chk("udf_level", 32'(lvl[0]), 32'd0);
      chk("udf_rd_valid", 32'(rv[0]), 32'd0);
      ce = 2'b11;
      cycle();
      idle();

      // Simultaneous write and read at level 1.
      wv[0] = 1'b1; wd[0] = 8'h11;
      cycle();
      wd[0] = 8'h55; rr[0] = 1'b1;
      cycle();
      idle();
      cycle();
      chk("wr_rd_l1_level", 32'(lvl[0]), 32'd1);
      chk("wr_rd_l1_data", 32'(rdd[0]), 32'h55);
      rr[0] = 1'b1;
      cycle();
      idle();

      // DEPTH=5 streaming with three words buffered so the memory pointers wrap.
      wv[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wd[1] = 8'(k);
         cycle();
      end
      rr[1] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         wd[1] = 8'(k + 3);
         @(negedge clk);
         chk("stream_data", 32'(rdd[1]), 32'(k));
         chk("stream_level", 32'(lvl[1]), 32'd3);
         @(posedge clk);
         #1;
         // Re-run the same cycle through the model path without a second edge.
         void'(q1.pop_front());
         q1.push_back(wd[1]);
      end
      idle();
      rr[1] = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      idle();
      cycle();

      // Randomized traffic on both instances.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < 2; i++) begin
            wv[i] = ($urandom_range(0, 99) < 60);
            rr[i] = ($urandom_range(0, 99) < ((k < 200) ? 45 : 65));
            ce[i] = ($urandom_range(0, 99) < 5);
            wd[i] = 8'($urandom);
         end
         cycle();
      end
      idle();
      cycle();

      // Reset in the middle of a stream.
      wv = 2'b11;
      for (int k = 0; k < 3; k++) begin
         wd = {8'(k + 8'h30), 8'(k + 8'h20)};
         cycle();
      end
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) check_inst(i);
      chk("rst_rd_data", 32'(rdd[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      wv[0] = 1'b1; wd[0] = 8'h7E;
      cycle();
      idle();
      cycle();
      chk("post_rst_head", 32'(rdd[0]), 32'h7E);
      chk("post_rst_valid", 32'(rv[0]), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
